// File: rtl/pixie_pkg.sv
// rtl/pixie_pkg.sv - shared Pixie/CDP1802 state codes and machine-cycle timing defaults
package pixie_pkg;

  typedef enum logic [1:0] {
    SC_FETCH = 2'b00,
    SC_EXEC  = 2'b01,
    SC_DMA   = 2'b10,
    SC_INT   = 2'b11
  } sc_t;

  localparam int DEFAULT_CLOCKS_PER_CYCLE = 8;
  localparam int DEFAULT_DATA_TICK        = 5;
  localparam int TICK_W                   = 3;

  // Only fetch/execute cycles belong to the core; it may touch R0 then.
  function automatic logic core_owned(input sc_t sc);
    return (sc == SC_FETCH) || (sc == SC_EXEC);
  endfunction

endpackage

// File: rtl/cdp1802_cycle_timer.sv
// rtl/cdp1802_cycle_timer.sv - tick counter within a machine cycle and boundary flag
module cdp1802_cycle_timer
  import pixie_pkg::*;
#(
  parameter int CLOCKS_PER_CYCLE = DEFAULT_CLOCKS_PER_CYCLE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk_enable,
  output logic [TICK_W-1:0] tick,
  output logic              boundary
);

  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(CLOCKS_PER_CYCLE - 1);

  assign boundary = (tick == LAST_TICK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick <= '0;
    end else if (clk_enable) begin
      tick <= boundary ? '0 : tick + 1'b1;
    end
  end

endmodule

// File: rtl/cdp1802_dma_responder.sv
// rtl/cdp1802_dma_responder.sv - CDP1802 machine-cycle sequencer servicing Pixie DMA-out and INT
// Optional DMA-in service is compiled in with DMA_IN_EN.
module cdp1802_dma_responder
  import pixie_pkg::*;
#(
  parameter int CLOCKS_PER_CYCLE = DEFAULT_CLOCKS_PER_CYCLE,
  parameter int DATA_TICK        = DEFAULT_DATA_TICK
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_enable,
  input  logic        dma_out_n,
  input  logic        int_req,
  input  logic        ie,
  input  logic        core_fetch_next,
  input  logic        r0_we,
  input  logic [15:0] r0_wdata,
  input  logic [7:0]  mem_rdata,
`ifdef DMA_IN_EN
  input  logic        dma_in_n,
  input  logic [7:0]  dma_in_data,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
`endif
  output logic [1:0]  SC,
  output logic [2:0]  tick,
  output logic        core_hold,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [7:0]  dma_data,
  output logic        dma_strobe,
  output logic        int_ack,
  output logic        ie_clr,
  output logic [15:0] r0
);

  localparam logic [TICK_W-1:0] DT      = TICK_W'(DATA_TICK);
  localparam logic [TICK_W-1:0] DT_NEXT = TICK_W'(DATA_TICK + 1);

  sc_t               sc_q;
  sc_t               next_sc;
  logic              boundary;
  logic [TICK_W-1:0] next_tick;
  logic [15:0]       next_r0;
  logic              grant_in;
  logic              in_q;
  logic              next_in;

  cdp1802_cycle_timer #(
    .CLOCKS_PER_CYCLE(CLOCKS_PER_CYCLE)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clk_enable(clk_enable),
    .tick      (tick),
    .boundary  (boundary)
  );

  assign SC        = sc_q;
  assign next_tick = boundary ? '0 : tick + 1'b1;
  assign next_in   = boundary ? grant_in : in_q;

  // Fixed grant priority evaluated only on the last tick of a cycle.
  always_comb begin
    next_sc  = sc_q;
    grant_in = 1'b0;
    if (boundary) begin
      if (!dma_out_n && sc_q != SC_FETCH) begin
        next_sc = SC_DMA;
`ifdef DMA_IN_EN
      end else if (!dma_in_n && sc_q != SC_FETCH) begin
        next_sc  = SC_DMA;
        grant_in = 1'b1;
`endif
      end else if (int_req && ie && (sc_q == SC_EXEC || sc_q == SC_DMA)) begin
        next_sc = SC_INT;
      end else if (sc_q == SC_FETCH) begin
        next_sc = SC_EXEC;
      end else if (sc_q == SC_INT) begin
        next_sc = SC_FETCH;
      end else begin
        next_sc = core_fetch_next ? SC_FETCH : SC_EXEC;
      end
    end
  end

  // The DMA post-increment always beats a core write; the core is held then anyway.
  always_comb begin
    next_r0 = r0;
    if (sc_q == SC_DMA && boundary) begin
      next_r0 = r0 + 16'd1;
    end else if (r0_we && core_owned(sc_q)) begin
      next_r0 = r0_wdata;
    end
  end

  // Outputs are registered from the next-state values so they line up with SC/tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sc_q       <= SC_EXEC;
      in_q       <= 1'b0;
      r0         <= '0;
      dma_data   <= '0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      core_hold  <= 1'b0;
      dma_strobe <= 1'b0;
      int_ack    <= 1'b0;
      ie_clr     <= 1'b0;
    end else if (clk_enable) begin
      sc_q       <= next_sc;
      in_q       <= next_in;
      r0         <= next_r0;
      mem_addr   <= (next_sc == SC_DMA) ? next_r0 : 16'd0;
      mem_rd     <= (next_sc == SC_DMA) && !next_in && (next_tick <= DT);
      core_hold  <= (next_sc == SC_DMA) || (next_sc == SC_INT);
      dma_strobe <= (next_sc == SC_DMA) && !next_in && (next_tick == DT_NEXT);
      int_ack    <= (next_sc == SC_INT) && (next_tick == '0);
      ie_clr     <= (next_sc == SC_INT) && (next_tick == '0);
      if (sc_q == SC_DMA && !in_q && tick == DT) begin
        dma_data <= mem_rdata;
      end
    end
  end

`ifdef DMA_IN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
    end else if (clk_enable) begin
      mem_wr <= (next_sc == SC_DMA) && next_in && (next_tick == DT);
      if (sc_q == SC_DMA && in_q && tick == '0) begin
        mem_wdata <= dma_in_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdp1802_dma_responder.sv
// tb/tb_cdp1802_dma_responder.sv - directed self-checking bench for cdp1802_dma_responder
module tb_cdp1802_dma_responder;

  logic        clk;
  logic        reset_n;
  logic        clk_enable;
  logic        dma_out_n;
  logic        int_req;
  logic        ie;
  logic        core_fetch_next;
  logic        r0_we;
  logic [15:0] r0_wdata;
  logic [7:0]  mem_rdata;
  logic [1:0]  SC;
  logic [2:0]  tick;
  logic        core_hold;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  dma_data;
  logic        dma_strobe;
  logic        int_ack;
  logic        ie_clr;
  logic [15:0] r0;
`ifdef DMA_IN_EN
  logic        dma_in_n;
  logic [7:0]  dma_in_data;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
`endif

  int compared;
  int mismatched;

  cdp1802_dma_responder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clk_enable     (clk_enable),
    .dma_out_n      (dma_out_n),
    .int_req        (int_req),
    .ie             (ie),
    .core_fetch_next(core_fetch_next),
    .r0_we          (r0_we),
    .r0_wdata       (r0_wdata),
    .mem_rdata      (mem_rdata),
`ifdef DMA_IN_EN
    .dma_in_n       (dma_in_n),
    .dma_in_data    (dma_in_data),
    .mem_wr         (mem_wr),
    .mem_wdata      (mem_wdata),
`endif
    .SC             (SC),
    .tick           (tick),
    .core_hold      (core_hold),
    .mem_addr       (mem_addr),
    .mem_rd         (mem_rd),
    .dma_data       (dma_data),
    .dma_strobe     (dma_strobe),
    .int_ack        (int_ack),
    .ie_clr         (ie_clr),
    .r0             (r0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: page 0x09 holds 0x10 + low byte, everything else low byte ^ 0x5A.
  always_comb begin
    if (mem_addr[15:8] == 8'h09) mem_rdata = 8'h10 + mem_addr[7:0];
    else                         mem_rdata = mem_addr[7:0] ^ 8'h5A;
  end

  task automatic next_cycle();
    int n = 0;
    while (tick !== 3'd7 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      compared++;
      mismatched++;
      $display("FAIL next_cycle_timeout tick=%0d required=7", tick);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (SC !== 2'b01 || tick !== 3'd0 || r0 !== 16'h0000 || dma_data !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_state SC=%b tick=%0d r0=%h dma_data=%h required 01/0/0000/00", SC, tick, r0, dma_data);
    end
    compared++;
    if ({mem_rd, core_hold, dma_strobe, int_ack, ie_clr} !== 5'b0 || mem_addr !== 16'h0000) begin
      mismatched++;
      $display("FAIL reset_outputs flags=%b mem_addr=%h required 00000/0000",
               {mem_rd, core_hold, dma_strobe, int_ack, ie_clr}, mem_addr);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_alternate();
    logic [1:0] exp_sc [4] = '{2'b00, 2'b01, 2'b00, 2'b01};
    for (int i = 0; i < 4; i++) begin
      core_fetch_next = (i % 2 == 0);
      next_cycle();
      compared++;
      if (SC !== exp_sc[i]) begin
        mismatched++;
        $display("FAIL alternate_sc[%0d] SC=%b required %b", i, SC, exp_sc[i]);
      end
    end
    core_fetch_next = 1'b0;
    compared++;
    if (r0 !== 16'h0000) begin
      mismatched++;
      $display("FAIL alternate_r0 r0=%h required 0000", r0);
    end
  endtask

  task automatic test_dma_burst();
    r0_we = 1'b1;
    r0_wdata = 16'h0900;
    @(negedge clk);
    r0_we = 1'b0;
    compared++;
    if (r0 !== 16'h0900) begin
      mismatched++;
      $display("FAIL r0_write r0=%h required 0900", r0);
    end
    dma_out_n = 1'b0;
    next_cycle();
    for (int k = 0; k < 8; k++) begin
      compared++;
      if (SC !== 2'b10 || mem_addr !== 16'h0900 + 16'(k) || mem_rd !== 1'b1 || core_hold !== 1'b1) begin
        mismatched++;
        $display("FAIL burst_start[%0d] SC=%b mem_addr=%h mem_rd=%b hold=%b required 10/%h/1/1",
                 k, SC, mem_addr, mem_rd, core_hold, 16'h0900 + 16'(k));
      end
      repeat (6) @(negedge clk);
      compared++;
      if (dma_strobe !== 1'b1 || dma_data !== 8'h10 + 8'(k) || mem_rd !== 1'b0) begin
        mismatched++;
        $display("FAIL burst_strobe[%0d] strobe=%b dma_data=%h mem_rd=%b required 1/%h/0",
                 k, dma_strobe, dma_data, mem_rd, 8'h10 + 8'(k));
      end
      if (k == 7) dma_out_n = 1'b1;
      next_cycle();
    end
    compared++;
    if (SC !== 2'b01 || r0 !== 16'h0908 || core_hold !== 1'b0) begin
      mismatched++;
      $display("FAIL burst_end SC=%b r0=%h hold=%b required 01/0908/0", SC, r0, core_hold);
    end
  endtask

  task automatic test_interrupt();
    core_fetch_next = 1'b1;
    next_cycle();
    core_fetch_next = 1'b0;
    int_req = 1'b1;
    ie = 1'b1;
    next_cycle();
    compared++;
    if (SC !== 2'b01 || int_ack !== 1'b0) begin
      mismatched++;
      $display("FAIL int_after_s0 SC=%b int_ack=%b required 01/0", SC, int_ack);
    end
    next_cycle();
    compared++;
    if (SC !== 2'b11 || int_ack !== 1'b1 || ie_clr !== 1'b1 || core_hold !== 1'b1 || mem_rd !== 1'b0) begin
      mismatched++;
      $display("FAIL int_grant SC=%b ack=%b clr=%b hold=%b rd=%b required 11/1/1/1/0",
               SC, int_ack, ie_clr, core_hold, mem_rd);
    end
    @(negedge clk);
    compared++;
    if (int_ack !== 1'b0 || ie_clr !== 1'b0) begin
      mismatched++;
      $display("FAIL int_pulse_width ack=%b clr=%b required 0/0", int_ack, ie_clr);
    end
    int_req = 1'b0;
    ie = 1'b0;
    next_cycle();
    compared++;
    if (SC !== 2'b00) begin
      mismatched++;
      $display("FAIL int_then_fetch SC=%b required 00", SC);
    end
    next_cycle();
  endtask

  task automatic test_priority();
    int_req = 1'b1;
    ie = 1'b1;
    dma_out_n = 1'b0;
    next_cycle();
    compared++;
    if (SC !== 2'b10) begin
      mismatched++;
      $display("FAIL prio_dma_first SC=%b required 10", SC);
    end
    next_cycle();
    compared++;
    if (SC !== 2'b10) begin
      mismatched++;
      $display("FAIL prio_dma_held SC=%b required 10", SC);
    end
    dma_out_n = 1'b1;
    next_cycle();
    compared++;
    if (SC !== 2'b11 || int_ack !== 1'b1 || r0 !== 16'h090A) begin
      mismatched++;
      $display("FAIL prio_int_after SC=%b ack=%b r0=%h required 11/1/090A", SC, int_ack, r0);
    end
    int_req = 1'b0;
    ie = 1'b0;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_wrap();
    r0_we = 1'b1;
    r0_wdata = 16'hFFFF;
    @(negedge clk);
    r0_we = 1'b0;
    dma_out_n = 1'b0;
    next_cycle();
    dma_out_n = 1'b1;
    compared++;
    if (SC !== 2'b10 || mem_addr !== 16'hFFFF) begin
      mismatched++;
      $display("FAIL wrap_addr SC=%b mem_addr=%h required 10/FFFF", SC, mem_addr);
    end
    @(negedge clk);
    r0_we = 1'b1;
    r0_wdata = 16'h1234;
    repeat (5) @(negedge clk);
    compared++;
    if (r0 !== 16'hFFFF || dma_data !== 8'hA5 || dma_strobe !== 1'b1) begin
      mismatched++;
      $display("FAIL wrap_s2 r0=%h dma_data=%h strobe=%b required FFFF/A5/1", r0, dma_data, dma_strobe);
    end
    next_cycle();
    r0_we = 1'b0;
    compared++;
    if (SC !== 2'b01 || r0 !== 16'h0000) begin
      mismatched++;
      $display("FAIL wrap_r0 SC=%b r0=%h required 01/0000", SC, r0);
    end
  endtask

  task automatic test_freeze();
    dma_out_n = 1'b0;
    next_cycle();
    dma_out_n = 1'b1;
    repeat (6) @(negedge clk);
    clk_enable = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (dma_strobe !== 1'b1 || tick !== 3'd6 || SC !== 2'b10) begin
      mismatched++;
      $display("FAIL freeze_hold strobe=%b tick=%0d SC=%b required 1/6/10", dma_strobe, tick, SC);
    end
    clk_enable = 1'b1;
    @(negedge clk);
    compared++;
    if (dma_strobe !== 1'b0 || tick !== 3'd7) begin
      mismatched++;
      $display("FAIL freeze_resume strobe=%b tick=%0d required 0/7", dma_strobe, tick);
    end
    next_cycle();
    compared++;
    if (r0 !== 16'h0001 || SC !== 2'b01) begin
      mismatched++;
      $display("FAIL freeze_r0 r0=%h SC=%b required 0001/01", r0, SC);
    end
  endtask

  task automatic test_reset_mid_s2();
    logic seen = 1'b0;
    dma_out_n = 1'b0;
    next_cycle();
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    dma_out_n = 1'b1;
    #1;
    compared++;
    if (SC !== 2'b01 || tick !== 3'd0 || r0 !== 16'h0000 || mem_rd !== 1'b0 ||
        mem_addr !== 16'h0000 || core_hold !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_s2 SC=%b tick=%0d r0=%h rd=%b addr=%h hold=%b required 01/0/0000/0/0000/0",
               SC, tick, r0, mem_rd, mem_addr, core_hold);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dma_strobe !== 1'b0) seen = 1'b1;
      if (i == 1) reset_n = 1'b1;
    end
    compared++;
    if (seen !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_no_strobe seen=%b required 0", seen);
    end
  endtask

`ifdef DMA_IN_EN
  task automatic test_dma_in();
    next_cycle();
    dma_in_n = 1'b0;
    dma_in_data = 8'hA5;
    next_cycle();
    dma_in_n = 1'b1;
    compared++;
    if (SC !== 2'b10) begin
      mismatched++;
      $display("FAIL dma_in_grant SC=%b required 10", SC);
    end
    @(negedge clk);
    dma_in_data = 8'h00;
    repeat (4) @(negedge clk);
    compared++;
    if (mem_wr !== 1'b1 || mem_wdata !== 8'hA5 || mem_rd !== 1'b0) begin
      mismatched++;
      $display("FAIL dma_in_write wr=%b wdata=%h rd=%b required 1/A5/0", mem_wr, mem_wdata, mem_rd);
    end
    @(negedge clk);
    compared++;
    if (mem_wr !== 1'b0 || dma_strobe !== 1'b0) begin
      mismatched++;
      $display("FAIL dma_in_pulse wr=%b strobe=%b required 0/0", mem_wr, dma_strobe);
    end
    next_cycle();
  endtask
`endif

  initial begin
    compared = 0;
    mismatched = 0;
    reset_n = 1'b0;
    clk_enable = 1'b1;
    dma_out_n = 1'b1;
    int_req = 1'b0;
    ie = 1'b0;
    core_fetch_next = 1'b0;
    r0_we = 1'b0;
    r0_wdata = 16'h0000;
`ifdef DMA_IN_EN
    dma_in_n = 1'b1;
    dma_in_data = 8'h00;
`endif
    test_reset();
    test_alternate();
    test_dma_burst();
    test_interrupt();
    test_priority();
    test_wrap();
    test_freeze();
    test_reset_mid_s2();
`ifdef DMA_IN_EN
    test_dma_in();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
